vec_exec_sequencer: RTL and testbench

Controller for the SIMD execute stage. It accepts one vector instruction at a time, with a vector length up to MAX_VL elements. It strip-mines the instruction into beats of LANES elements over consecutive vector registers: for each beat it drives register-file read addresses, the execute-stage op_code and enable, then issues the matching masked register-file write once the execute latency has elapsed. It sits between decode/issue and the execute stage plus vector register file.

---
 rtl/vec_exec_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_vec_exec_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_exec_sequencer.sv
// vec_exec_sequencer: controller for the SIMD execute stage.
// Accepts one vector instruction at a time and splits it into beats of LANES
// elements. Each beat goes to a consecutive vector register. For each beat it
// drives the register-file read addresses, the execute op_code and the execute
// enable. After EXE_LAT cycles it issues the matching masked register-file
// write.
//
// Optional build macro: VEC_SEQ_STALL_EN adds the input 'stall', which pauses
// beat issue while the sequencer is in ISSUE.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   req_valid/ready     instruction handshake (accepted only in IDLE)
//   req_op/vd/vs1/vs2   op_code, destination and source base registers
//   req_vl              element count (clipped to MAX_VL)
//   rf_ra1/rf_ra2       register-file read addresses for the current beat
//   exe_op_code/enable  execute-stage op and beat valid
//   rf_we/wa/wmask      register-file write port for completed beats
//   busy, done          instruction in progress / one-cycle completion pulse
module vec_exec_sequencer #(
  parameter int unsigned LANES   = 4,
  parameter int unsigned MAX_VL  = 32,
  parameter int unsigned EXE_LAT = 1,
  parameter int unsigned VL_W    = 6
) (
  input  logic             clk,
  input  logic             reset,
`ifdef VEC_SEQ_STALL_EN
  input  logic             stall,
`endif
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [4:0]       req_vd,
  input  logic [4:0]       req_vs1,
  input  logic [4:0]       req_vs2,
  input  logic [VL_W-1:0]  req_vl,
  output logic [4:0]       rf_ra1,
  output logic [4:0]       rf_ra2,
  output logic [3:0]       exe_op_code,
  output logic             exe_enable,
  output logic             rf_we,
  output logic [4:0]       rf_wa,
  output logic [LANES-1:0] rf_wmask,
  output logic             busy,
  output logic             done
);

  localparam int unsigned AW  = 5;
  localparam int unsigned OPW = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [AW-1:0]    ra1_q, ra1_d;
  logic [AW-1:0]    ra2_q, ra2_d;
  logic [AW-1:0]    wa_q, wa_d;
  // Elements still to be issued, counting the current beat.
  logic [VL_W-1:0]  rem_q, rem_d;

  // Write-back pipeline: one entry per execute latency cycle.
  logic [EXE_LAT-1:0] pv_q, pv_d;
  logic [AW-1:0]      pwa_q [EXE_LAT];
  logic [AW-1:0]      pwa_d [EXE_LAT];
  logic [LANES-1:0]   pm_q  [EXE_LAT];
  logic [LANES-1:0]   pm_d  [EXE_LAT];

  logic             issue_stall;
  logic             issue;
  logic [VL_W-1:0]  vl_eff;
  logic [LANES-1:0] beat_mask;

`ifdef VEC_SEQ_STALL_EN
  assign issue_stall = stall;
`else
  assign issue_stall = 1'b0;
`endif

  // Clip the requested length to the maximum vector length.
  always_comb begin
    vl_eff = req_vl;
    if (req_vl > VL_W'(MAX_VL)) begin
      vl_eff = VL_W'(MAX_VL);
    end
  end

  // Lane i is written if more than i elements remain. This gives all ones
  // for full beats and the low r bits for the final partial beat.
  always_comb begin
    beat_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      beat_mask[i] = (rem_q > VL_W'(i));
    end
  end

  assign issue = (state_q == S_ISSUE) && !issue_stall;

  // Next-state logic, beat bookkeeping and write-pipeline advance.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ra1_d   = ra1_q;
    ra2_d   = ra2_q;
    wa_d    = wa_q;
    rem_d   = rem_q;

    pv_d[0]  = issue;
    pwa_d[0] = wa_q;
    pm_d[0]  = beat_mask;
    for (int i = 1; i < EXE_LAT; i++) begin
      pv_d[i]  = pv_q[i-1];
      pwa_d[i] = pwa_q[i-1];
      pm_d[i]  = pm_q[i-1];
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          ra1_d = req_vs1;
          ra2_d = req_vs2;
          wa_d  = req_vd;
          rem_d = vl_eff;
          if (vl_eff == '0) begin
            state_d = S_DONE;
          end else begin
            // The op only changes when a beat is about to issue, so
            // exe_op_code holds its value between instructions.
            op_d    = req_op;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          ra1_d = ra1_q + AW'(1);
          ra2_d = ra2_q + AW'(1);
          wa_d  = wa_q + AW'(1);
          if (rem_q <= VL_W'(LANES)) begin
            rem_d   = '0;
            state_d = S_DRAIN;
          end else begin
            rem_d = rem_q - VL_W'(LANES);
          end
        end
      end
      S_DRAIN: begin
        // Leave once the last write has left the pipeline.
        if (pv_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and pipeline registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ra1_q   <= '0;
      ra2_q   <= '0;
      wa_q    <= '0;
      rem_q   <= '0;
      pv_q    <= '0;
      for (int i = 0; i < EXE_LAT; i++) begin
        pwa_q[i] <= '0;
        pm_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ra1_q   <= ra1_d;
      ra2_q   <= ra2_d;
      wa_q    <= wa_d;
      rem_q   <= rem_d;
      pv_q    <= pv_d;
      for (int i = 0; i < EXE_LAT; i++) begin
        pwa_q[i] <= pwa_d[i];
        pm_q[i]  <= pm_d[i];
      end
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign exe_enable  = issue;
  assign exe_op_code = op_q;
  assign rf_ra1      = ra1_q;
  assign rf_ra2      = ra2_q;
  assign rf_we       = pv_q[EXE_LAT-1];
  assign rf_wa       = pwa_q[EXE_LAT-1];
  assign rf_wmask    = pm_q[EXE_LAT-1];

endmodule

// File: tb/tb_vec_exec_sequencer.sv
// Testbench for vec_exec_sequencer.
// A per-cycle schedule of expected outputs is built from each accepted
// instruction. A single compare process checks the DUT against that schedule
// every cycle. Directed scenarios add literal checks at known cycles.
module tb_vec_exec_sequencer;

  localparam int LANES   = 4;
  localparam int MAX_VL  = 32;
  localparam int EXE_LAT = 1;
  localparam int VL_W    = 6;
  localparam int NC      = 2000;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_op;
  logic [4:0]       req_vd;
  logic [4:0]       req_vs1;
  logic [4:0]       req_vs2;
  logic [VL_W-1:0]  req_vl;
  logic [4:0]       rf_ra1;
  logic [4:0]       rf_ra2;
  logic [3:0]       exe_op_code;
  logic             exe_enable;
  logic             rf_we;
  logic [4:0]       rf_wa;
  logic [LANES-1:0] rf_wmask;
  logic             busy;
  logic             done;

  vec_exec_sequencer #(
    .LANES(LANES), .MAX_VL(MAX_VL), .EXE_LAT(EXE_LAT), .VL_W(VL_W)
  ) dut (
    .clk(clk),
    .reset(reset),
`ifdef VEC_SEQ_STALL_EN
    .stall(1'b0),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op(req_op),
    .req_vd(req_vd),
    .req_vs1(req_vs1),
    .req_vs2(req_vs2),
    .req_vl(req_vl),
    .rf_ra1(rf_ra1),
    .rf_ra2(rf_ra2),
    .exe_op_code(exe_op_code),
    .exe_enable(exe_enable),
    .rf_we(rf_we),
    .rf_wa(rf_wa),
    .rf_wmask(rf_wmask),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  int n_checks;
  int n_err;
  bit finished;

  // Expected outputs, indexed by cycle number.
  int exp_ready [NC];
  int exp_busy  [NC];
  int exp_done  [NC];
  int exp_en    [NC];
  int exp_ra1   [NC];
  int exp_ra2   [NC];
  int exp_op    [NC];
  int exp_we    [NC];
  int exp_wa    [NC];
  int exp_mask  [NC];

  task automatic chk(input string name, input int got, input int expv);
    n_checks++;
    if (got != expv) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, expv);
    end
  endtask

  // Everything from cycle 'from' onward returns to the idle picture.
  task automatic model_clear(input int from);
    for (int i = from; i < NC; i++) begin
      exp_ready[i] = 1; exp_busy[i] = 0; exp_done[i] = 0;
      exp_en[i] = 0; exp_ra1[i] = 0; exp_ra2[i] = 0; exp_op[i] = 0;
      exp_we[i] = 0; exp_wa[i] = 0; exp_mask[i] = 0;
    end
  endtask

  // Build the expected timeline for an instruction accepted in cycle t.
  task automatic schedule(input int t, input int op, input int vd,
                          input int vs1, input int vs2, input int vl);
    int vle, nb, td, c, w, r;
    vle = (vl > MAX_VL) ? MAX_VL : vl;
    nb  = (vle + LANES - 1) / LANES;
    td  = (vle == 0) ? t + 1 : t + 1 + nb + EXE_LAT;
    for (int k = 0; k < nb; k++) begin
      c = t + 1 + k;
      w = c + EXE_LAT;
      r = vle - k * LANES;
      if (c < NC) begin
        exp_en[c] = 1; exp_op[c] = op;
        exp_ra1[c] = (vs1 + k) % 32; exp_ra2[c] = (vs2 + k) % 32;
      end
      if (w < NC) begin
        exp_we[w] = 1; exp_wa[w] = (vd + k) % 32;
        exp_mask[w] = (r >= LANES) ? (1 << LANES) - 1 : (1 << r) - 1;
      end
    end
    for (int i = t + 1; i <= td && i < NC; i++) begin
      exp_ready[i] = 0; exp_busy[i] = 1;
    end
    if (td < NC) exp_done[td] = 1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    req_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) step();
  endtask

  // Present one instruction in the first cycle the model says is idle.
  task automatic send(input int op, input int vd, input int vs1,
                      input int vs2, input int vl, output int t);
    int guard;
    guard = 0;
    while (exp_ready[cyc] == 0 && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) chk("send_timeout", 0, 1);
    req_op = 4'(op); req_vd = 5'(vd); req_vs1 = 5'(vs1);
    req_vs2 = 5'(vs2); req_vl = VL_W'(vl);
    req_valid = 1'b1;
    schedule(cyc, op, vd, vs1, vs2, vl);
    t = cyc;
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (!finished && cyc >= 1 && cyc < NC) begin
      chk("req_ready", int'(req_ready), exp_ready[cyc]);
      chk("busy", int'(busy), exp_busy[cyc]);
      chk("done", int'(done), exp_done[cyc]);
      chk("exe_enable", int'(exe_enable), exp_en[cyc]);
      chk("rf_we", int'(rf_we), exp_we[cyc]);
      if (exp_en[cyc] != 0) begin
        chk("rf_ra1", int'(rf_ra1), exp_ra1[cyc]);
        chk("rf_ra2", int'(rf_ra2), exp_ra2[cyc]);
        chk("exe_op_code", int'(exe_op_code), exp_op[cyc]);
      end
      if (exp_we[cyc] != 0) begin
        chk("rf_wa", int'(rf_wa), exp_wa[cyc]);
        chk("rf_wmask", int'(rf_wmask), exp_mask[cyc]);
      end
    end
  end

  initial begin
    int t;
    cyc = 0; n_checks = 0; n_err = 0; finished = 1'b0;
    reset = 1'b1; req_valid = 1'b0;
    req_op = '0; req_vd = '0; req_vs1 = '0; req_vs2 = '0; req_vl = '0;
    model_clear(0);

    // Reset values.
    step();
    chk("rst_ready", int'(req_ready), 1);
    chk("rst_op", int'(exe_op_code), 0);
    chk("rst_wa", int'(rf_wa), 0);
    chk("rst_mask", int'(rf_wmask), 0);
    chk("rst_ra1", int'(rf_ra1), 0);
    step();
    step();
    reset = 1'b0;

    // Single full beat.
    send(1, 2, 4, 6, 4, t);
    wait_cyc(t + 1);
    chk("s1_ra1", int'(rf_ra1), 4);
    chk("s1_ra2", int'(rf_ra2), 6);
    chk("s1_en", int'(exe_enable), 1);
    chk("s1_op", int'(exe_op_code), 1);
    wait_cyc(t + 2);
    chk("s1_we", int'(rf_we), 1);
    chk("s1_wa", int'(rf_wa), 2);
    chk("s1_mask", int'(rf_wmask), 15);
    wait_cyc(t + 3);
    chk("s1_done", int'(done), 1);
    wait_cyc(t + 4);
    chk("s1_ready", int'(req_ready), 1);

    // Partial last beat.
    send(1, 2, 4, 6, 10, t);
    wait_cyc(t + 3);
    chk("s2_ra1_last", int'(rf_ra1), 6);
    wait_cyc(t + 4);
    chk("s2_wa_last", int'(rf_wa), 4);
    chk("s2_mask_last", int'(rf_wmask), 3);
    wait_cyc(t + 5);
    chk("s2_done", int'(done), 1);

    // Zero length.
    send(3, 1, 1, 1, 0, t);
    wait_cyc(t + 1);
    chk("s3_done", int'(done), 1);
    chk("s3_en", int'(exe_enable), 0);
    wait_cyc(t + 2);
    chk("s3_ready", int'(req_ready), 1);

    // Register address wrap.
    send(2, 31, 30, 0, 8, t);
    wait_cyc(t + 2);
    chk("s4_ra1", int'(rf_ra1), 31);
    chk("s4_wa0", int'(rf_wa), 31);
    wait_cyc(t + 3);
    chk("s4_wa1", int'(rf_wa), 0);
    chk("s4_mask", int'(rf_wmask), 15);

    // Length clipped to MAX_VL.
    send(5, 0, 8, 16, 40, t);
    wait_cyc(t + 9);
    chk("s5_we_last", int'(rf_we), 1);
    chk("s5_mask_last", int'(rf_wmask), 15);
    wait_cyc(t + 10);
    chk("s5_done", int'(done), 1);

    // Reset in the middle of an instruction.
    send(4, 8, 12, 20, 16, t);
    wait_cyc(t + 2);
    reset = 1'b1;
    model_clear(t + 3);
    step();
    reset = 1'b0;
    chk("s6_en", int'(exe_enable), 0);
    chk("s6_we", int'(rf_we), 0);
    chk("s6_ready", int'(req_ready), 1);

    // Random traffic with occasional resets.
    for (int n = 0; n < 1500; n++) begin
      step();
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        model_clear(cyc + 1);
      end else begin
        reset = 1'b0;
        req_op  = 4'($urandom_range(0, 15));
        req_vd  = 5'($urandom_range(0, 31));
        req_vs1 = 5'($urandom_range(0, 31));
        req_vs2 = 5'($urandom_range(0, 31));
        req_vl  = VL_W'($urandom_range(0, 40));
        req_valid = ($urandom_range(0, 2) != 0);
        if (req_valid && exp_ready[cyc] != 0) begin
          schedule(cyc, int'(req_op), int'(req_vd), int'(req_vs1),
                   int'(req_vs2), int'(req_vl));
        end
      end
    end
    step();
    reset = 1'b0;
    for (int n = 0; n < 20; n++) step();

    finished = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
